tinker_mem_arbiter: RTL
=======================

Name: tinker_mem_arbiter

Overview:
Shares one single-ported, variable-latency memory port between the Tinker core's instruction-fetch requester and its data load/store requester. The arbiter selects one requester, issues exactly one memory access, waits for completion, and returns data with a one-cycle done pulse. Data accesses have priority; a streak counter guarantees fetch progress. It sits between the core's fetch/control logic and the memory, enabling multicycle core sequencing.

Parameters:
MAX_DATA_STREAK, 4, maximum consecutive data grants while fetch is pending (legal range 1 to 15)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held high with if_addr stable until if_done
if_addr  in  32  fetch byte address
if_rdata  out  32  fetched instruction, mem_rdata[31:0] of the last completed fetch
if_done  out  1  one-cycle fetch completion pulse
d_req  in  1  data request; held high with d_we/d_addr/d_wdata stable until d_done
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data byte address
d_wdata  in  64  store data
d_rdata  out  64  load data from the last completed load
d_done  out  1  one-cycle data completion pulse (loads and stores)
mem_en  out  1  one-cycle access strobe
mem_we  out  1  access is a write
mem_addr  out  32  access address
mem_wdata  out  64  write data
mem_rdata  in  64  read data, valid with mem_rvalid
mem_rvalid  in  1  access completion (reads and writes), at least 1 cycle after mem_en
busy  out  1  high in every state except IDLE
owner  out  1  0 = fetch, 1 = data; the current or most recent grant

Behaviour:
- Reset: synchronous, active-high, reset on clk; all outputs 0; state IDLE; streak = 0. Applied mid-access, it abandons the access. Any mem_rvalid for that access is ignored, and no done pulse is generated.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if d_req or if_req is sampled high, grant a requester, latch owner/addr/we/wdata into mem_*, and go to ISSUE. Otherwise stay.
- Grant rule when both requests are high: grant data unless streak == MAX_DATA_STREAK, in which case grant fetch.
- Streak update at grant:
  - data grant with if_req high: streak + 1 (saturating at 15)
  - data grant with if_req low: streak = 0
  - fetch grant: streak = 0
- A fetch grant drives mem_we = 0 and mem_wdata = 0.
- ISSUE: mem_en = 1 for exactly this cycle. Always go to WAIT.
- WAIT: mem_en = 0. mem_addr/mem_we/mem_wdata stay stable from ISSUE until leaving WAIT. On mem_rvalid, go to DONE and update data as follows:
  - fetch: capture mem_rdata[31:0] into if_rdata
  - load: capture mem_rdata into d_rdata
  - store: d_rdata unchanged
- DONE: if_done or d_done = 1 according to owner, for one cycle. No arbitration in this cycle; a req sampled here is ignored. Always go to IDLE.
- mem_rvalid sampled in IDLE, ISSUE or DONE is ignored.
- Minimum access timing (request seen at cycle 0, mem_rvalid at cycle 2):
  - mem_en at cycle 1
  - done at cycle 3
  - next grant evaluated at cycle 4
  - per-access throughput: 4 cycles plus extra memory latency
- if_rdata and d_rdata hold their values until the next completion on that port.
- A requester dropping req before done is illegal. The arbiter still completes the access and pulses done.
- Address arithmetic is none; addresses pass through unmodified (no alignment check).

Test Plan:
- Fetch only, memory latency 1: if_req, if_addr=0x2000, mem_rdata=0x1234_5678_9ABC_DEF0 → mem_en at cycle 1 with mem_addr=0x2000 and mem_we=0; if_done at cycle 3 with if_rdata=0x9ABC_DEF0; d_done stays 0.
- Store then load, latency 3: store with d_addr=0x10000, d_wdata=0xCAFE → mem_we=1 and mem_wdata=0xCAFE held through WAIT; d_done at cycle 5; d_rdata stays 0. A following load returning 0xCAFE → d_rdata=0xCAFE.
- Simultaneous requests in IDLE, MAX_DATA_STREAK=4 → data granted first (owner=1); fetch granted on the next arbitration.
- Fairness, MAX_DATA_STREAK=2, d_req and if_req held continuously (data requester re-requests after each done) → grant order data, data, fetch, data, data, fetch.
- Reset asserted in WAIT, then mem_rvalid pulses after reset → no done pulse, all outputs 0, busy=0; a fresh fetch afterwards completes normally.
- Spurious mem_rvalid in IDLE and ISSUE → ignored: state, if_rdata and d_rdata unchanged; no done pulse.

Source files
------------

// File: rtl/tinker_mem_arbiter.sv
// rtl/tinker_mem_arbiter.sv - shares one variable-latency memory port between fetch and data requesters
module tinker_mem_arbiter #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic [63:0] d_rdata,
    output logic        d_done,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0] STREAK_LIMIT = 4'(MAX_DATA_STREAK);
    localparam logic [3:0] STREAK_SAT   = 4'd15;

    state_t      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic        owner_q, owner_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [63:0] d_rdata_q, d_rdata_d;
    logic        if_done_q, if_done_d;
    logic        d_done_q, d_done_d;
    logic        busy_q, busy_d;
    logic        grant_data;

    // Next-state logic: arbitration in IDLE, one strobe in ISSUE, completion capture in WAIT.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        owner_d     = owner_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        grant_data  = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_req || if_req) begin
                    // Data wins unless it has starved a waiting fetch for the full streak.
                    grant_data = d_req && !(if_req && (streak_q == STREAK_LIMIT));
                    owner_d    = grant_data;
                    mem_en_d   = 1'b1;
                    state_d    = ISSUE;
                    if (grant_data) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        if (if_req) begin
                            streak_d = (streak_q == STREAK_SAT) ? STREAK_SAT : streak_q + 4'd1;
                        end else begin
                            streak_d = 4'd0;
                        end
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = 64'd0;
                        streak_d    = 4'd0;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = DONE;
                    if (!owner_q) begin
                        if_rdata_d = mem_rdata[31:0];
                        if_done_d  = 1'b1;
                    end else begin
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                        d_done_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            streak_q    <= 4'd0;
            owner_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 64'd0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 64'd0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            owner_q     <= owner_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            busy_q      <= busy_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_done   = if_done_q;
    assign d_rdata   = d_rdata_q;
    assign d_done    = d_done_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule
